// File: rtl/ocm_sample_writer_if.sv
// OCM port-2 write bus shared between the sample writer and the memory.
//   addr2       word address
//   wen2        single-cycle write strobe
//   writedata2  write data, lane 0 in the least significant bits
//   byteenable2 one enable bit per sample lane
// master = writer side (drives the bus), slave = memory side.
interface ocm_sample_writer_if #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 64,
  parameter int LANES      = 8
);
  logic [ADDR_WIDTH-1:0] addr2;
  logic                  wen2;
  logic [DATA_WIDTH-1:0] writedata2;
  logic [LANES-1:0]      byteenable2;

  modport master (output addr2, output wen2, output writedata2, output byteenable2);
  modport slave  (input  addr2, input  wen2, input  writedata2, input  byteenable2);
endinterface

// File: rtl/ocm_sample_writer.sv
// Packs a stream of channel samples into OCM words and writes NUM_WORDS
// words starting at BASE_ADDR, stepping ADDR_STEP per word.
// Ports:
//   clk, rstn        clock (rising edge), synchronous active-low reset
//   start            begin a capture run (honoured in IDLE/DONE only)
//   flush            write any partial word and end the run early
//   sample_in/_valid sample stream, accepted only in CAPTURE
//   ocm (master)     OCM port-2 write bus, all outputs registered
//   busy, done       run status
//   word_count       words written in the current run
//
// state   | meaning
// IDLE    | waiting for start after reset
// CAPTURE | assembling samples into lanes, writing each full word
// DRAIN   | last write of the run on the bus (wen2 high)
// DONE    | run complete, waiting for next start
module ocm_sample_writer #(
  parameter int SIGNAL_RESOLUTION = 8,
  parameter int DATA_WIDTH        = 64,
  parameter int ADDR_WIDTH        = 14,
  parameter int BASE_ADDR         = 'h400,
  parameter int ADDR_STEP         = 4,
  parameter int NUM_WORDS         = 16
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic                               start,
  input  logic                               flush,
  input  logic [SIGNAL_RESOLUTION-1:0]       sample_in,
  input  logic                               sample_in_valid,
  ocm_sample_writer_if.master                ocm,
  output logic                               busy,
  output logic                               done,
  output logic [$clog2(NUM_WORDS+1)-1:0]     word_count
);

  localparam int LANES  = DATA_WIDTH / SIGNAL_RESOLUTION;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int WC_W   = $clog2(NUM_WORDS + 1);
  localparam int SR     = SIGNAL_RESOLUTION;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
  localparam logic [1:0] ST_DRAIN   = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  logic [1:0]            state;
  logic [LANE_W-1:0]     lane;
  logic [DATA_WIDTH-1:0] asm_data;
  logic [ADDR_WIDTH-1:0] addr_ptr;

  logic [DATA_WIDTH-1:0] asm_next;
  logic [LANE_W:0]       fill_cnt;
  logic [LANES-1:0]      be_mask;
  logic                  last_lane;
  logic [ADDR_WIDTH-1:0] addr_inc;
  logic [WC_W-1:0]       wc_inc;

  // asm_next already includes a same-cycle valid sample, so a flush and a
  // sample on the same edge land in one write.
  always_comb begin
    asm_next = asm_data;
    if (sample_in_valid) begin
      for (int i = 0; i < LANES; i++) begin
        if (lane == LANE_W'(i)) asm_next[i*SR +: SR] = sample_in;
      end
    end
    fill_cnt = {1'b0, lane} + (LANE_W+1)'(sample_in_valid);
    for (int i = 0; i < LANES; i++) begin
      be_mask[i] = ((LANE_W+1)'(i) < fill_cnt);
    end
    last_lane = (lane == LANE_W'(LANES - 1));
    // Truncation to ADDR_WIDTH gives the modulo-2^ADDR_WIDTH wrap.
    addr_inc  = addr_ptr + ADDR_WIDTH'(ADDR_STEP);
    wc_inc    = word_count + WC_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state           <= ST_IDLE;
      lane            <= '0;
      asm_data        <= '0;
      addr_ptr        <= '0;
      word_count      <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      ocm.wen2        <= 1'b0;
      ocm.addr2       <= '0;
      ocm.writedata2  <= '0;
      ocm.byteenable2 <= '0;
    end else begin
      ocm.wen2 <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state      <= ST_CAPTURE;
            addr_ptr   <= ADDR_WIDTH'(BASE_ADDR);
            lane       <= '0;
            asm_data   <= '0;
            word_count <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
          end
        end
        ST_CAPTURE: begin
          if (sample_in_valid && last_lane) begin
            ocm.wen2        <= 1'b1;
            ocm.addr2       <= addr_ptr;
            ocm.writedata2  <= asm_next;
            ocm.byteenable2 <= '1;
            lane            <= '0;
            asm_data        <= '0;
            addr_ptr        <= addr_inc;
            word_count      <= wc_inc;
            if (flush || (wc_inc == WC_W'(NUM_WORDS))) state <= ST_DRAIN;
          end else if (flush) begin
            if (fill_cnt != '0) begin
              ocm.wen2        <= 1'b1;
              ocm.addr2       <= addr_ptr;
              ocm.writedata2  <= asm_next;
              ocm.byteenable2 <= be_mask;
              lane            <= '0;
              asm_data        <= '0;
              addr_ptr        <= addr_inc;
              word_count      <= wc_inc;
              state           <= ST_DRAIN;
            end else begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end else if (sample_in_valid) begin
            asm_data <= asm_next;
            lane     <= lane + LANE_W'(1);
          end
        end
        ST_DRAIN: begin
          state <= ST_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ocm_sample_writer.sv
module tb_ocm_sample_writer;

  typedef struct {
    logic [13:0] addr;
    logic [63:0] data;
    logic [7:0]  be;
  } wr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn = 1'b0;
  logic       start1 = 1'b0, flush1 = 1'b0, valid1 = 1'b0;
  logic [7:0] sample1 = '0;
  logic       busy1, done1;
  logic [4:0] wc1;

  logic       start2 = 1'b0, flush2 = 1'b0, valid2 = 1'b0;
  logic [7:0] sample2 = '0;
  logic       busy2, done2;
  logic [1:0] wc2;

  ocm_sample_writer_if #(.ADDR_WIDTH(14), .DATA_WIDTH(64), .LANES(8)) bus1 ();
  ocm_sample_writer_if #(.ADDR_WIDTH(14), .DATA_WIDTH(64), .LANES(8)) bus2 ();

  ocm_sample_writer dut1 (
    .clk(clk), .rstn(rstn), .start(start1), .flush(flush1),
    .sample_in(sample1), .sample_in_valid(valid1), .ocm(bus1.master),
    .busy(busy1), .done(done1), .word_count(wc1)
  );

  ocm_sample_writer #(.BASE_ADDR('h3FFC), .ADDR_STEP(4), .NUM_WORDS(2)) dut2 (
    .clk(clk), .rstn(rstn), .start(start2), .flush(flush2),
    .sample_in(sample2), .sample_in_valid(valid2), .ocm(bus2.master),
    .busy(busy2), .done(done2), .word_count(wc2)
  );

  int  errors = 0;
  int  checks = 0;
  wr_t q1[$];
  wr_t q2[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pack_seq(input logic [7:0] first);
    logic [63:0] d;
    for (int i = 0; i < 8; i++) d[i*8 +: 8] = first + 8'(i);
    return d;
  endfunction

  function automatic wr_t mk(input logic [13:0] a, input logic [63:0] d, input logic [7:0] b);
    wr_t w;
    w.addr = a; w.data = d; w.be = b;
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares every write strobe against the scoreboard queues.
  logic prev_wen1 = 1'b0, prev_wen2 = 1'b0;
  always @(negedge clk) begin
    wr_t e;
    if (bus1.wen2) begin
      if (q1.size() == 0) begin
        errors++; checks++;
        $display("FAIL dut1 unexpected write: addr=%0h data=%0h be=%0h expected none",
                 bus1.addr2, bus1.writedata2, bus1.byteenable2);
      end else begin
        e = q1.pop_front();
        chk("dut1 addr2", 64'(bus1.addr2), 64'(e.addr));
        chk("dut1 writedata2", bus1.writedata2, e.data);
        chk("dut1 byteenable2", 64'(bus1.byteenable2), 64'(e.be));
      end
      if (prev_wen1) chk("dut1 wen2 pulse width", 64'd2, 64'd1);
    end
    if (bus2.wen2) begin
      if (q2.size() == 0) begin
        errors++; checks++;
        $display("FAIL dut2 unexpected write: addr=%0h data=%0h expected none",
                 bus2.addr2, bus2.writedata2);
      end else begin
        e = q2.pop_front();
        chk("dut2 addr2", 64'(bus2.addr2), 64'(e.addr));
        chk("dut2 writedata2", bus2.writedata2, e.data);
        chk("dut2 byteenable2", 64'(bus2.byteenable2), 64'(e.be));
      end
      if (prev_wen2) chk("dut2 wen2 pulse width", 64'd2, 64'd1);
    end
    prev_wen1 = bus1.wen2;
    prev_wen2 = bus2.wen2;
  end

  task automatic chk_reset1(input string tag);
    chk({tag, " wen2"}, 64'(bus1.wen2), 64'd0);
    chk({tag, " addr2"}, 64'(bus1.addr2), 64'd0);
    chk({tag, " writedata2"}, bus1.writedata2, 64'd0);
    chk({tag, " byteenable2"}, 64'(bus1.byteenable2), 64'd0);
    chk({tag, " busy"}, 64'(busy1), 64'd0);
    chk({tag, " done"}, 64'(done1), 64'd0);
    chk({tag, " word_count"}, 64'(wc1), 64'd0);
  endtask

  task automatic start_run1();
    start1 = 1'b1; tick(); start1 = 1'b0;
    chk("start busy", 64'(busy1), 64'd1);
    chk("start done", 64'(done1), 64'd0);
  endtask

  initial begin
    // Reset state
    tick(); tick();
    chk_reset1("reset");
    chk("reset dut2 busy", 64'(busy2), 64'd0);
    rstn = 1'b1;
    tick();

    // Full run: 128 samples 0x00..0x7F back to back
    start_run1();
    for (int i = 0; i < 128; i++) begin
      sample1 = 8'(i); valid1 = 1'b1;
      if (i % 8 == 7)
        q1.push_back(mk(14'('h400 + 4*(i/8)),
                        (i == 7) ? 64'h0706050403020100 : pack_seq(8'(i - 7)), 8'hFF));
      tick();
    end
    valid1 = 1'b0;
    chk("run1 last write wen2", 64'(bus1.wen2), 64'd1);
    chk("run1 done during drain", 64'(done1), 64'd0);
    chk("run1 busy during drain", 64'(busy1), 64'd1);
    tick();
    chk("run1 done", 64'(done1), 64'd1);
    chk("run1 busy", 64'(busy1), 64'd0);
    chk("run1 word_count", 64'(wc1), 64'd16);
    tick();
    chk("run1 done holds", 64'(done1), 64'd1);

    // Valid every other cycle, with an ignored start mid-run
    start_run1();
    for (int c = 0; c < 128; c++) begin
      valid1 = (c % 2 == 0);
      sample1 = valid1 ? 8'h10 + 8'(c / 2) : 8'hEE;
      start1 = (c == 20);
      if (c % 16 == 14)
        q1.push_back(mk(14'('h400 + 4*(c/16)), pack_seq(8'h10 + 8'(8*(c/16))), 8'hFF));
      tick();
    end
    valid1 = 1'b0; start1 = 1'b0;
    chk("toggle word_count", 64'(wc1), 64'd8);
    chk("toggle busy", 64'(busy1), 64'd1);
    // Flush on an empty lane: no write, straight to DONE
    flush1 = 1'b1; tick(); flush1 = 1'b0;
    chk("empty flush done", 64'(done1), 64'd1);
    chk("empty flush word_count", 64'(wc1), 64'd8);
    // Samples in DONE are ignored
    for (int i = 0; i < 5; i++) begin
      sample1 = 8'h99; valid1 = 1'b1; tick();
    end
    valid1 = 1'b0;
    chk("done ignore word_count", 64'(wc1), 64'd8);
    chk("done ignore addr2", 64'(bus1.addr2), 64'h41C);
    chk("done ignore writedata2", bus1.writedata2, pack_seq(8'h48));

    // 11 samples then flush on the following cycle
    start_run1();
    for (int i = 0; i < 11; i++) begin
      sample1 = 8'hA0 + 8'(i); valid1 = 1'b1;
      if (i == 7) q1.push_back(mk(14'h400, 64'hA7A6A5A4A3A2A1A0, 8'hFF));
      tick();
    end
    valid1 = 1'b0; flush1 = 1'b1;
    q1.push_back(mk(14'h404, 64'h0000000000AAA9A8, 8'b00000111));
    tick(); flush1 = 1'b0;
    chk("partial flush drain busy", 64'(busy1), 64'd1);
    tick();
    chk("partial flush done", 64'(done1), 64'd1);
    chk("partial flush word_count", 64'(wc1), 64'd2);

    // Flush together with a valid sample into lane 2
    start_run1();
    sample1 = 8'h30; valid1 = 1'b1; tick();
    sample1 = 8'h31; tick();
    sample1 = 8'h32; flush1 = 1'b1;
    q1.push_back(mk(14'h400, 64'h0000000000323130, 8'b00000111));
    tick(); valid1 = 1'b0; flush1 = 1'b0;
    tick();
    chk("flush+sample done", 64'(done1), 64'd1);
    chk("flush+sample word_count", 64'(wc1), 64'd1);

    // Flush together with the sample filling the last lane
    start_run1();
    for (int i = 0; i < 8; i++) begin
      sample1 = 8'h50 + 8'(i); valid1 = 1'b1; flush1 = (i == 7);
      if (i == 7) q1.push_back(mk(14'h400, 64'h5756555453525150, 8'hFF));
      tick();
    end
    valid1 = 1'b0; flush1 = 1'b0;
    chk("flush+full drain busy", 64'(busy1), 64'd1);
    tick();
    chk("flush+full done", 64'(done1), 64'd1);
    chk("flush+full word_count", 64'(wc1), 64'd1);

    // Reset after 5 samples discards the partial word
    start_run1();
    for (int i = 0; i < 5; i++) begin
      sample1 = 8'hF0 + 8'(i); valid1 = 1'b1; tick();
    end
    rstn = 1'b0; sample1 = 8'hF5; tick();
    chk_reset1("midrun reset");
    sample1 = 8'hF6; tick();
    valid1 = 1'b0; rstn = 1'b1; tick();
    start_run1();
    for (int i = 0; i < 8; i++) begin
      sample1 = 8'hC0 + 8'(i); valid1 = 1'b1;
      if (i == 7) q1.push_back(mk(14'h400, 64'hC7C6C5C4C3C2C1C0, 8'hFF));
      tick();
    end
    valid1 = 1'b0;
    chk("restart word_count", 64'(wc1), 64'd1);
    flush1 = 1'b1; tick(); flush1 = 1'b0;
    chk("restart done", 64'(done1), 64'd1);

    // Address wrap on the second instance
    start2 = 1'b1; tick(); start2 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      sample2 = 8'h60 + 8'(i); valid2 = 1'b1;
      if (i == 7)  q2.push_back(mk(14'h3FFC, 64'h6766656463626160, 8'hFF));
      if (i == 15) q2.push_back(mk(14'h0000, 64'h6F6E6D6C6B6A6968, 8'hFF));
      tick();
    end
    valid2 = 1'b0;
    tick();
    chk("wrap done", 64'(done2), 64'd1);
    chk("wrap word_count", 64'(wc2), 64'd2);

    tick(); tick();
    chk("dut1 pending writes", 64'(q1.size()), 64'd0);
    chk("dut2 pending writes", 64'(q2.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
